// File: rtl/layer_pkg.sv
// Shared types for the layer boundary serializer.
package layer_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      SHIFT   = 1'b1
   } ser_state_t;

endpackage

// File: rtl/layer_serializer.sv
// Collects NN per-neuron results, then replays them word-serially (neuron 0 first).
// Optional LAYER_SER_OVERRUN_EN: sticky flag for i_valid pulses dropped during SHIFT.
module layer_serializer
   import layer_pkg::*;
#(
   parameter int NN        = 30,
   parameter int dataWidth = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NN-1:0]           i_valid,
   input  logic [NN*dataWidth-1:0] x_in,
   output logic                    x_valid,
   output logic [dataWidth-1:0]    x_out,
   output logic                    x_last,
   output logic                    busy,
   output logic                    overrun
);

   localparam int              IDXW     = (NN > 1) ? $clog2(NN) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NN - 1);

   ser_state_t                   state_q, state_d;
   logic [NN-1:0]                got_q, got_d;
   logic [NN-1:0][dataWidth-1:0] buf_q, buf_d;
   logic [IDXW-1:0]              idx_q, idx_d;
   logic                         x_valid_q, x_valid_d;
   logic                         x_last_q, x_last_d;
   logic [dataWidth-1:0]         x_out_q, x_out_d;
   logic                         accept;
   logic [NN-1:0]                got_eff;

   // The edge after the last word already behaves as COLLECT, so the next
   // layer's results can be captured (or even complete) with no dead cycle.
   always_comb begin
      accept    = (state_q == COLLECT) || x_last_q;
      got_eff   = (state_q == COLLECT) ? got_q : '0;
      state_d   = state_q;
      got_d     = got_q;
      buf_d     = buf_q;
      idx_d     = idx_q;
      x_valid_d = x_valid_q;
      x_last_d  = x_last_q;
      x_out_d   = x_out_q;
      if (accept) begin
         for (int i = 0; i < NN; i++) begin
            if (i_valid[i]) buf_d[i] = x_in[i*dataWidth +: dataWidth];
         end
         got_d     = got_eff | i_valid;
         state_d   = COLLECT;
         x_valid_d = 1'b0;
         x_last_d  = 1'b0;
         idx_d     = '0;
         if (&got_d) begin
            // buf_d carries the bypassed slices captured on this same edge
            state_d   = SHIFT;
            x_valid_d = 1'b1;
            x_out_d   = buf_d[0];
            x_last_d  = (NN == 1);
            idx_d     = IDXW'(1);
         end
      end else begin
         x_out_d  = buf_q[idx_q];
         x_last_d = (idx_q == LAST_IDX);
         idx_d    = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= COLLECT;
         got_q     <= '0;
         idx_q     <= '0;
         x_valid_q <= 1'b0;
         x_last_q  <= 1'b0;
         x_out_q   <= '0;
      end else begin
         state_q   <= state_d;
         got_q     <= got_d;
         idx_q     <= idx_d;
         x_valid_q <= x_valid_d;
         x_last_q  <= x_last_d;
         x_out_q   <= x_out_d;
      end
   end

   // Capture bank holds data only; got_q says what is meaningful.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

`ifdef LAYER_SER_OVERRUN_EN
   logic overrun_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) overrun_q <= 1'b0;
      else       overrun_q <= overrun_q | (!accept && (|i_valid));
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign x_valid = x_valid_q;
   assign x_out   = x_out_q;
   assign x_last  = x_last_q;
   assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_layer_serializer.sv
// Randomized and directed bench for layer_serializer (NN=4 plus an NN=1 instance).
module tb_layer_serializer;

   localparam int NN = 4;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic [NN-1:0]    i_valid;
   logic [NN*DW-1:0] x_in;
   logic             x_valid, x_last, busy, overrun;
   logic [DW-1:0]    x_out;

   logic             iv1;
   logic [DW-1:0]    x1_in;
   logic             x1_valid, x1_last, busy1, overrun1;
   logic [DW-1:0]    x1_out;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: capture slots plus a queue of words still to be emitted.
   logic [DW-1:0] mbuf [NN];
   logic [NN-1:0] mgot;
   logic [DW-1:0] mq [$];
   logic          e_valid, e_last, e_ovr;
   logic [DW-1:0] e_out;
   logic          ovr_en;

   layer_serializer #(.NN(NN), .dataWidth(DW)) u_dut (
      .clk(clk), .rstn(rstn), .i_valid(i_valid), .x_in(x_in),
      .x_valid(x_valid), .x_out(x_out), .x_last(x_last),
      .busy(busy), .overrun(overrun)
   );

   layer_serializer #(.NN(1), .dataWidth(DW)) u_dut1 (
      .clk(clk), .rstn(rstn), .i_valid(iv1), .x_in(x1_in),
      .x_valid(x1_valid), .x_out(x1_out), .x_last(x1_last),
      .busy(busy1), .overrun(overrun1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [NN*DW-1:0] pk(input logic [DW-1:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic model_reset();
      mq.delete();
      mgot    = '0;
      e_valid = 1'b0;
      e_last  = 1'b0;
      e_ovr   = 1'b0;
      e_out   = '0;
   endtask

   task automatic model_edge(input logic [NN-1:0] iv, input logic [NN*DW-1:0] xv);
      if (mq.size() > 0) begin
         e_out   = mq.pop_front();
         e_last  = (mq.size() == 0);
         e_valid = 1'b1;
         if (ovr_en && (|iv)) e_ovr = 1'b1;
      end else begin
         for (int i = 0; i < NN; i++)
            if (iv[i]) begin
               mbuf[i] = xv[i*DW +: DW];
               mgot[i] = 1'b1;
            end
         if (&mgot) begin
            e_out   = mbuf[0];
            for (int i = 1; i < NN; i++) mq.push_back(mbuf[i]);
            e_valid = 1'b1;
            e_last  = 1'b0;
            mgot    = '0;
         end else begin
            e_valid = 1'b0;
            e_last  = 1'b0;
         end
      end
   endtask

   task automatic step(input logic [NN-1:0] iv, input logic [NN*DW-1:0] xv);
      i_valid = iv;
      x_in    = xv;
      @(posedge clk);
      model_edge(iv, xv);
      #1;
      chk("valid", {31'b0, x_valid}, {31'b0, e_valid});
      chk("last", {31'b0, x_last}, {31'b0, e_last});
      chk("busy", {31'b0, busy}, {31'b0, e_valid});
      chk("overrun", {31'b0, overrun}, {31'b0, e_ovr});
      if (e_valid) chk("data", {16'b0, x_out}, {16'b0, e_out});
   endtask

   initial begin
      logic [NN*DW-1:0] d;
`ifdef LAYER_SER_OVERRUN_EN
      ovr_en = 1'b1;
`else
      ovr_en = 1'b0;
`endif
      rstn = 1'b0; i_valid = '0; x_in = '0; iv1 = 1'b0; x1_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, x_valid}, 32'd0);
      chk("rst_last", {31'b0, x_last}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_out", {16'b0, x_out}, 32'd0);
      chk("rst_ovr", {31'b0, overrun}, 32'd0);
      chk("rst1_valid", {31'b0, x1_valid}, 32'd0);
      rstn = 1'b1;

      // simultaneous capture
      step(4'hF, pk(16'h0011, 16'h0022, 16'h0033, 16'h0044));
      chk("sim_w0", {16'b0, x_out}, 32'h0011);
      step('0, '0); chk("sim_w1", {16'b0, x_out}, 32'h0022);
      step('0, '0); chk("sim_w2", {16'b0, x_out}, 32'h0033);
      step('0, '0); chk("sim_w3", {16'b0, x_out}, 32'h0044);
      chk("sim_last", {31'b0, x_last}, 32'd1);
      step('0, '0); chk("sim_end", {31'b0, x_valid}, 32'd0);

      // staggered capture with overwrite
      step(4'b0100, pk(16'h0, 16'h0, 16'h0100, 16'h0));
      step('0, '0);
      step('0, '0);
      step(4'b0001, pk(16'h0A00, 16'h0, 16'h0, 16'h0));
      step(4'b0100, pk(16'h0, 16'h0, 16'h0200, 16'h0));
      step('0, '0);
      chk("stag_idle", {31'b0, x_valid}, 32'd0);
      step(4'b1010, pk(16'h0, 16'h1111, 16'h0, 16'h3333));
      chk("stag_w0", {16'b0, x_out}, 32'h0A00);
      step('0, '0); chk("stag_w1", {16'b0, x_out}, 32'h1111);
      step('0, '0); chk("stag_w2", {16'b0, x_out}, 32'h0200);
      step('0, '0); chk("stag_w3", {16'b0, x_out}, 32'h3333);
      step('0, '0);

      // back-to-back collections
      step(4'hF, pk(16'h1001, 16'h1002, 16'h1003, 16'h1004));
      repeat (3) step('0, '0);
      step(4'hF, pk(16'h2001, 16'h2002, 16'h2003, 16'h2004));
      chk("b2b_valid", {31'b0, x_valid}, 32'd1);
      chk("b2b_w0", {16'b0, x_out}, 32'h2001);
      chk("b2b_ovr", {31'b0, overrun}, 32'd0);
      repeat (4) step('0, '0);

      // pulse during word 2 of a burst
      step(4'hF, pk(16'h3001, 16'h3002, 16'h3003, 16'h3004));
      step('0, '0);
      step('0, '0);
      step(4'b0010, pk(16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF));
      chk("ovr_w3", {16'b0, x_out}, 32'h3004);
      chk("ovr_flag", {31'b0, overrun}, {31'b0, ovr_en});
      repeat (2) step('0, '0);

      // mid-burst reset
      step(4'hF, pk(16'h4001, 16'h4002, 16'h4003, 16'h4004));
      step('0, '0);
      #2 rstn = 1'b0;
      #1;
      chk("mrst_valid", {31'b0, x_valid}, 32'd0);
      chk("mrst_last", {31'b0, x_last}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      chk("mrst_out", {16'b0, x_out}, 32'd0);
      chk("mrst_ovr", {31'b0, overrun}, 32'd0);
      model_reset();
      rstn = 1'b1;
      step(4'hF, pk(16'h5001, 16'h5002, 16'h5003, 16'h5004));
      chk("post_rst_w0", {16'b0, x_out}, 32'h5001);
      repeat (4) step('0, '0);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         logic [NN-1:0] iv;
         for (int i = 0; i < NN; i++) iv[i] = ($urandom_range(0, 3) == 0);
         d = {$urandom(), $urandom()};
         step(iv, d);
      end

      // NN=1 instance
      i_valid = '0;
      iv1 = 1'b1; x1_in = 16'h7FFF;
      @(posedge clk); #1;
      iv1 = 1'b0; x1_in = '0;
      chk("n1_valid", {31'b0, x1_valid}, 32'd1);
      chk("n1_last", {31'b0, x1_last}, 32'd1);
      chk("n1_busy", {31'b0, busy1}, 32'd1);
      chk("n1_out", {16'b0, x1_out}, 32'h7FFF);
      @(posedge clk); #1;
      chk("n1_end_valid", {31'b0, x1_valid}, 32'd0);
      chk("n1_end_last", {31'b0, x1_last}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/layer_serializer.md
# layer_serializer

Parallel-to-serial adapter between two neuron layers. Collects the `NN` per-neuron results of one layer (each neuron asserts its own valid pulse, not necessarily in the same cycle), holds them in a capture buffer, then replays them as a word-serial `x_valid`/`x_out` stream that the next layer's broadcast input consumes. The block is the producer end of the layer input stream, one instance per layer boundary.

## Interface
Parameters:
- `NN`, 30: neuron count of the upstream layer, ≥1.
- `dataWidth`, 16: word width, fixed-point, passed through unchanged.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `i_valid`  in  `NN`: per-neuron output-valid pulses; bit i qualifies slice i.
- `x_in`  in  `NN*dataWidth`: neuron i result at `[i*dataWidth +: dataWidth]`.
- `x_valid`  out  1: serial word valid.
- `x_out`  out  `dataWidth`: serial word, neuron 0 first.
- `x_last`  out  1: high with `x_valid` on word `NN-1`.
- `busy`  out  1: high while in SHIFT.
- `overrun`  out  1: sticky overrun flag; see Configuration.

## Operation
- States: COLLECT (reset state), SHIFT.
- COLLECT: per neuron, `i_valid[i]`=1 → `buf[i]` ← slice i, `got[i]` ← 1. A repeat pulse on an already-captured neuron overwrites `buf[i]`; newest value wins.
- Completion: on the edge where `got | i_valid` becomes all ones → SHIFT, `idx` ← 1, `x_valid` ← 1, `x_out` ← word 0. Word 0 is taken from `x_in` when `i_valid[0]` is high on that edge, otherwise from `buf[0]`; this bypass applies to every slice captured on the completing edge.
- SHIFT: each edge drives `x_out` ← `buf[idx]` and increments `idx`. `x_last` is registered high alongside word `NN-1`. On the edge after the last word: `x_valid`, `x_last` ← 0, `got` ← 0, `idx` ← 0 → COLLECT.
- In SHIFT, `i_valid` is ignored and the buffer stays stable.
- `NN`=1: one-cycle burst, with `x_valid` and `x_last` both high in that cycle.
- No downstream backpressure. Neurons consume one word per cycle.
- `idx` width is `$clog2(NN)`, minimum 1. Data passes through with no arithmetic.

## Timing
- Reset values: `x_valid`=0, `x_out`=0, `x_last`=0, `busy`=0, `overrun`=0. Internally `got`=0, `idx`=0, state COLLECT. `buf` is not reset.
- Reset asserted mid-burst aborts the burst immediately. After release the block is in COLLECT with nothing captured.
- Completing `i_valid` sampled at edge k → word j is on `x_out` in the cycle after edge k+j, j=0..NN-1. `x_valid` is low after edge k+NN.
- Burst is exactly `NN` consecutive cycles with `x_valid` high and no gaps.
- A valid pulse sampled at edge k+NN is accepted as the first capture of the next collection. Back-to-back collections therefore have no dead cycle beyond the burst.
- `busy` equals the registered SHIFT state and matches `x_valid`.

## Configuration
- `LAYER_SER_OVERRUN_EN` defined: any `i_valid` bit high while in SHIFT sets `overrun` ← 1 on that edge. The flag clears only on reset.
- Not defined: `overrun` is tied to 0. Pulses in SHIFT are still silently dropped.

## Structure
- Shared package `layer_pkg`: state enum typedef `ser_state_t` {COLLECT, SHIFT}.
- No sub-module. Capture bank, FSM and output register stay in one module.

## Test plan
(NN=4, dataWidth=16 unless noted.)
- Simultaneous capture: `i_valid`=4'b1111, words 0x0011/0x0022/0x0033/0x0044 in one cycle → next 4 cycles `x_out`=0x0011, 0x0022, 0x0033, 0x0044. `x_valid`=1 throughout; `x_last` only on 0x0044.
- Staggered capture with overwrite: neuron 2 at cycle 0 (0x0100), neuron 0 at cycle 3 (0x0A00), neuron 2 again at cycle 4 (0x0200), neurons 1 and 3 at cycle 6 → burst starts cycle 7 with order 0x0A00, n1, 0x0200, n3.
- Overrun: with `LAYER_SER_OVERRUN_EN`, pulse `i_valid[1]` during word 2 of a burst → `overrun`=1 from next cycle, burst data unchanged. Without the macro, `overrun` stays 0.
- Mid-burst reset: drop `rstn` during word 1 → all outputs 0 immediately. After release, a full capture produces a clean 4-word burst.
- Back-to-back: second full `i_valid` asserted in the cycle sampled at edge k+4 → second burst starts at cycle k+5, no gap, no overrun.
- NN=1: single pulse with 0x7FFF → one cycle with `x_valid`=`x_last`=`busy`=1 and `x_out`=0x7FFF.
